// File: rtl/pipe_if_id_reg_if.sv
// Bundles the IF-stage results, the decode-side controls and the IF/ID register outputs.
// The master side is the pipeline around this block; the slave side is the register block.
interface pipe_if_id_reg_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      npc_in;
  logic [31:0]      pc4_in;
  logic [31:0]      ins_in;
  logic             id_ready;
  logic             flush;
  logic [31:0]      pc_out;
  logic [31:0]      d_pc;
  logic [31:0]      d_pc4;
  logic [31:0]      d_ins;
  logic             d_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output npc_in, pc4_in, ins_in, id_ready, flush,
    input  pc_out, d_pc, d_pc4, d_ins, d_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  npc_in, pc4_in, ins_in, id_ready, flush,
    output pc_out, d_pc, d_pc4, d_ins, d_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_if_id_reg.sv
// Program counter plus IF/ID pipeline register with stall, flush-to-bubble and
// saturating stall/flush performance counters. Every output comes straight from a flop.
module pipe_if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_if_id_reg_if.slave    bus
);

  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [31:0]      r_pc;
  logic [31:0]      r_dPc;
  logic [31:0]      r_dPc4;
  logic [31:0]      r_dIns;
  logic             r_dValid;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  logic             w_stallSat;
  logic             w_flushSat;
  logic             w_flushTaken;

  assign w_stallSat   = &r_stallCnt;
  assign w_flushSat   = &r_flushCnt;
  // A stalled ID cannot resolve control flow, so flush only counts when ID advances.
  assign w_flushTaken = bus.id_ready & bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_dPc    <= 32'h0;
      r_dPc4   <= 32'h0;
      r_dIns   <= 32'h0;
      r_dValid <= 1'b0;
    end else if (bus.id_ready) begin
      r_pc   <= bus.npc_in;
      r_dPc  <= r_pc;
      r_dPc4 <= bus.pc4_in;
      if (bus.flush) begin
        r_dIns   <= 32'h0;
        r_dValid <= 1'b0;
      end else begin
        r_dIns   <= bus.ins_in;
        r_dValid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (!bus.id_ready && !w_stallSat) begin
        r_stallCnt <= r_stallCnt + CntOne;
      end
      if (w_flushTaken && !w_flushSat) begin
        r_flushCnt <= r_flushCnt + CntOne;
      end
    end
  end

  assign bus.pc_out    = r_pc;
  assign bus.d_pc      = r_dPc;
  assign bus.d_pc4     = r_dPc4;
  assign bus.d_ins     = r_dIns;
  assign bus.d_valid   = r_dValid;
  assign bus.stall_cnt = r_stallCnt;
  assign bus.flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_pipe_if_id_reg.sv
// Directed plus random checking of pipe_if_id_reg against a transaction-level
// model that tracks architectural PC, IF/ID slot contents and raw event counts.
module tb_pipe_if_id_reg;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam int          CntW    = 4;
  localparam int          CntMax  = 15;

  logic clk;
  logic rst;

  pipe_if_id_reg_if #(.CNT_W(CntW)) bus ();

  pipe_if_id_reg #(.RESET_PC(ResetPc), .CNT_W(CntW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: the slot contents and unbounded event counts.
  logic [31:0] mPc, mDPc, mDPc4, mDIns;
  logic        mDValid;
  int          mStalls, mFlushes;
  int          asserts, failCount;

  function automatic logic [CntW-1:0] satCount(input int n);
    return (n > CntMax) ? CntW'(CntMax) : CntW'(n);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string step);
    checkVal({step, ".pc_out"},    bus.pc_out,             mPc);
    checkVal({step, ".d_pc"},      bus.d_pc,               mDPc);
    checkVal({step, ".d_pc4"},     bus.d_pc4,              mDPc4);
    checkVal({step, ".d_ins"},     bus.d_ins,              mDIns);
    checkVal({step, ".d_valid"},   {31'h0, bus.d_valid},   {31'h0, mDValid});
    checkVal({step, ".stall_cnt"}, {28'h0, bus.stall_cnt}, {28'h0, satCount(mStalls)});
    checkVal({step, ".flush_cnt"}, {28'h0, bus.flush_cnt}, {28'h0, satCount(mFlushes)});
  endtask

  // pc4_in always tracks the model PC, as the IF adder would.
  task automatic applyStimulus(input logic r, input logic rdy, input logic fl,
                               input logic [31:0] npc, input logic [31:0] ins);
    rst          = r;
    bus.id_ready = rdy;
    bus.flush    = fl;
    bus.npc_in   = npc;
    bus.ins_in   = ins;
    bus.pc4_in   = mPc + 32'd4;
  endtask

  // Advance one edge, update the model from the inputs seen there, then sample.
  task automatic clockEdge(input string step);
    @(posedge clk);
    if (rst) begin
      mPc = ResetPc; mDPc = 0; mDPc4 = 0; mDIns = 0; mDValid = 0;
      mStalls = 0; mFlushes = 0;
    end else if (!bus.id_ready) begin
      mStalls++;
    end else begin
      mDPc    = mPc;
      mDPc4   = bus.pc4_in;
      mDIns   = bus.flush ? 32'h0 : bus.ins_in;
      mDValid = !bus.flush;
      if (bus.flush) mFlushes++;
      mPc     = bus.npc_in;
    end
    #1;
    checkOutput(step);
  endtask

  initial begin
    asserts = 0; failCount = 0;
    mPc = ResetPc; mDPc = 0; mDPc4 = 0; mDIns = 0; mDValid = 0;
    mStalls = 0; mFlushes = 0;

    // Reset for two edges, then the first fetch.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEC, 32'hFFFF_FFFF);
    clockEdge("reset0");
    clockEdge("reset1");
    checkVal("reset.pc_const", bus.pc_out, 32'h0040_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0040_0004, 32'h2008_0005);
    clockEdge("first");
    checkVal("first.d_ins_const", bus.d_ins, 32'h2008_0005);
    checkVal("first.d_pc_const",  bus.d_pc,  32'h0040_0000);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0040_0008, 32'h0000_1111);
    clockEdge("adv");

    // Three stall cycles with changing npc_in.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0050_0000 + 32'(i * 4), 32'hAAAA_0000 + 32'(i));
      clockEdge("stall");
    end
    checkVal("stall.cnt3", {28'h0, bus.stall_cnt}, 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0040_000C, 32'h0000_2222);
    clockEdge("resume");
    checkVal("resume.d_ins", bus.d_ins, 32'h0000_2222);

    // Flush with a redirect, then the first instruction at the target.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0040_0100, 32'h0000_3333);
    clockEdge("flush");
    checkVal("flush.pc_const", bus.pc_out, 32'h0040_0100);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0040_0104, 32'h0000_4444);
    clockEdge("target");
    checkVal("target.d_pc_const", bus.d_pc, 32'h0040_0100);

    // Stall and flush together: flush is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0060_0000, 32'h0000_5555);
    clockEdge("stallflush");
    checkVal("stallflush.fcnt", {28'h0, bus.flush_cnt}, 32'd1);

    // Long stall to saturate the stall counter.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      clockEdge("sat");
    end
    checkVal("sat.cnt_max", {28'h0, bus.stall_cnt}, 32'h0000_000F);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, $urandom);
      clockEdge("rand");
    end

    // Build up valid state, then a reset glitch between edges must do nothing.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0040_0200, 32'h0000_6666);
    clockEdge("pre");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0040_0204, 32'h0000_7777);
    clockEdge("prestall");
    rst = 1'b1;
    #2;
    rst = 1'b0;
    clockEdge("glitch");

    // Reset asserted in the middle of a stall.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0070_0000, 32'h0000_8888);
    clockEdge("midreset");
    checkVal("midreset.valid", {31'h0, bus.d_valid}, 32'h0);
    checkVal("midreset.pc",    bus.pc_out,           32'h0040_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_if_id_reg.md
Name: pipe_if_id_reg

Overview:
Sequential front end of the 5-stage pipeline. It holds the program counter feeding the IF stage and the IF/ID pipeline register feeding ID. It consumes the IF-stage outputs (next PC, PC+4, fetched instruction) and applies decode-side stall and flush. It also keeps saturating performance counters for stall and flush cycles.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
npc_in  input  32  next PC selected by IF mux (pc4/branch/jr/jump)
pc4_in  input  32  PC+4 of instruction currently fetched
ins_in  input  32  instruction fetched at pc_out
id_ready  input  1  1 = ID accepts a new instruction; 0 = load-use/hazard stall
flush  input  1  1 = control transfer resolved in ID; squash the wrong-path fetch
pc_out  output  32  current PC, drives IF instruction-memory address
d_pc  output  32  PC of the instruction held in IF/ID
d_pc4  output  32  PC+4 of the instruction held in IF/ID
d_ins  output  32  instruction held in IF/ID (32'h0 = NOP when bubble)
d_valid  output  1  1 = d_ins is a real instruction
stall_cnt  output  CNT_W  cycles with id_ready=0 since reset, saturating
flush_cnt  output  CNT_W  accepted flushes since reset, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge): pc_out=RESET_PC, d_pc=0, d_pc4=0, d_ins=0, d_valid=0, stall_cnt=0, flush_cnt=0. Reset overrides all other inputs. Asserting rst mid-stall or mid-flush discards all in-flight state.
- After reset is released, the first IF/ID contents appear one cycle later. d_valid stays 0 for exactly the first post-reset cycle.
- Per-edge priority when rst=0:
  1. id_ready=0 (stall): pc_out, d_pc, d_pc4, d_ins and d_valid all hold their values. flush is ignored, because a stalled ID instruction cannot resolve control flow. stall_cnt increments.
  2. id_ready=1, flush=1: pc_out<=npc_in (the redirect target). IF/ID becomes a bubble: d_valid<=0, d_ins<=0, d_pc<=pc_out, d_pc4<=pc4_in. flush_cnt increments.
  3. id_ready=1, flush=0: pc_out<=npc_in, d_pc<=pc_out, d_pc4<=pc4_in, d_ins<=ins_in, d_valid<=1.
- Latency: one cycle from IF to the IF/ID outputs. The PC redirect takes effect on the edge at which flush is accepted. Exactly one wrong-path slot is squashed; there is no delay slot.
- Bubble content: a bubble always presents d_ins=0 (sll $0,$0,0). Downstream logic may use either d_valid or the zero encoding.
- Counters: CNT_W-bit unsigned. They hold at all-ones (2^CNT_W-1) and never wrap. stall and flush are mutually exclusive per cycle, so at most one counter changes per edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Arithmetic: only the counter increments. PC values pass through unmodified; no alignment checks are made in this block.

Test Plan:
1. Reset with RESET_PC=32'h0040_0000: hold rst=1 for 2 cycles, then release. -> pc_out=32'h0040_0000, d_valid=0, d_ins=0, both counters 0. On the next edge, with npc_in=32'h0040_0004 and ins_in=32'h2008_0005 -> pc_out=32'h0040_0004, d_pc=32'h0040_0000, d_ins=32'h2008_0005, d_valid=1.
2. Stall: id_ready=0 for 3 cycles with npc_in changing every cycle. -> pc_out and all d_* outputs frozen, stall_cnt=3. Then id_ready=1 -> normal advance resumes with no lost or duplicated instruction.
3. Flush: id_ready=1, flush=1, npc_in=32'h0040_0100. -> next cycle pc_out=32'h0040_0100, d_valid=0, d_ins=0, flush_cnt=1. The following cycle d_pc=32'h0040_0100.
4. Simultaneous stall and flush: id_ready=0, flush=1. -> no state change, flush_cnt unchanged, stall_cnt+1.
5. Counter saturation with CNT_W=4: 20 stall cycles -> stall_cnt=4'hF, and it stays 4'hF.
6. Reset mid-operation: assert rst during a stall, with d_valid=1 and counters non-zero. -> the next edge restores all reset values. A glitch on rst between edges has no effect.
